// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the multi-channel fan controller.
// Holds the setting-to-duty replication rule and the PWM period length rule.
// Pure constants and functions; no clocked logic lives here.
package fan_ctrl_pkg;

  // Widest PWM resolution the helpers below can represent.
  localparam int MaxPwmWidth = 31;

  // Last value of the period counter before it wraps: one period is
  // 2^pwm_width-1 ticks, so the counter runs 0..2^pwm_width-2.
  function automatic int period_max(input int pwm_width);
    return (1 << pwm_width) - 2;
  endfunction

  // Replicate a setting pwm_width/setting_width times so that all-ones maps
  // to full scale and zero maps to zero (e.g. 4->8 bits: 0x8 -> 0x88).
  function automatic logic [MaxPwmWidth-1:0] expand_setting(
    input logic [MaxPwmWidth-1:0] setting,
    input int                     setting_width,
    input int                     pwm_width
  );
    logic [MaxPwmWidth-1:0] mask;
    logic [MaxPwmWidth-1:0] acc;
    mask = (MaxPwmWidth'(1) << setting_width) - MaxPwmWidth'(1);
    acc  = '0;
    for (int i = 0; i < pwm_width / setting_width; i++) begin
      acc = (acc << setting_width) | (setting & mask);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fan_ctrl_multi_chan.sv
// One fan channel: duty ramp, PWM compare, tach sync/edge detect, watchdog, stall flag.
// PWM output registered one cycle after cnt/duty; duty moves only at period wrap.
// No backpressure; stall flag is sticky until cleared while no timeout is present.
module fan_ctrl_chan
  import fan_ctrl_pkg::*;
#(
  parameter int SettingWidth = 4,
  parameter int PwmWidth     = 8,
  parameter int RampStep     = 16,
  parameter int TachTimeout  = 100000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    tick_i,
  input  logic                    wrap_i,
  input  logic [PwmWidth-1:0]     cnt_i,
  input  logic [SettingWidth-1:0] setting_i,
  input  logic                    tach_i,
  input  logic                    stall_clr_i,
  output logic                    pwm_o,
  output logic                    stall_o,
  output logic [PwmWidth-1:0]     duty_o
);

  localparam int                  WdWidth = $clog2(TachTimeout + 1);
  localparam logic [WdWidth-1:0]  WdMax   = WdWidth'(TachTimeout);
  localparam logic [PwmWidth-1:0] StepN   = PwmWidth'(RampStep);
  localparam logic [PwmWidth:0]   Step    = {1'b0, StepN};

  logic [PwmWidth-1:0] r_duty;
  logic                r_pwm;
  logic                r_tach_meta;
  logic                r_tach_sync;
  logic                r_tach_prev;
  logic [WdWidth-1:0]  r_wd;
  logic                r_stall;

  logic [PwmWidth-1:0] w_target;
  logic [PwmWidth:0]   w_tgt_x;
  logic [PwmWidth:0]   w_duty_x;
  logic [PwmWidth:0]   w_diff;
  logic [PwmWidth-1:0] w_duty_next;
  logic                w_tach_rise;
  logic                w_timeout;

  assign w_target    = PwmWidth'(expand_setting(MaxPwmWidth'(setting_i), SettingWidth, PwmWidth));
  assign w_tach_rise = r_tach_sync & ~r_tach_prev;
  assign w_timeout   = (r_wd == WdMax);

  // Next duty: jump to target when within one step, else move one step toward it.
  // One extra bit keeps the difference free of wrap-around.
  always_comb begin
    w_tgt_x     = {1'b0, w_target};
    w_duty_x    = {1'b0, r_duty};
    w_diff      = '0;
    w_duty_next = r_duty;
    if (w_tgt_x >= w_duty_x) begin
      w_diff      = w_tgt_x - w_duty_x;
      w_duty_next = (w_diff <= Step) ? w_target : (r_duty + StepN);
    end else begin
      w_diff      = w_duty_x - w_tgt_x;
      w_duty_next = (w_diff <= Step) ? w_target : (r_duty - StepN);
    end
  end

  // Applied duty: zeroed while disabled, otherwise updated only at period wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_duty <= '0;
    end else if (!en_i) begin
      r_duty <= '0;
    end else if (wrap_i) begin
      r_duty <= w_duty_next;
    end
  end

  // Registered PWM compare; all-ones duty stays high because cnt never reaches all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= en_i && (cnt_i < r_duty);
    end
  end

  // Two-flop synchronizer for the asynchronous tach input plus a delayed copy for edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tach_meta <= 1'b0;
      r_tach_sync <= 1'b0;
      r_tach_prev <= 1'b0;
    end else begin
      r_tach_meta <= tach_i;
      r_tach_sync <= r_tach_meta;
      r_tach_prev <= r_tach_sync;
    end
  end

  // Watchdog: counts ticks since the last tach rise while the fan is driven; saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd <= '0;
    end else if (!en_i || w_tach_rise || (r_duty == '0)) begin
      r_wd <= '0;
    end else if (tick_i && !w_timeout) begin
      r_wd <= r_wd + WdWidth'(1);
    end
  end

  // Sticky stall flag; a standing timeout overrides a clear, and disable keeps the flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall <= 1'b0;
    end else if (w_timeout) begin
      r_stall <= 1'b1;
    end else if (stall_clr_i) begin
      r_stall <= 1'b0;
    end
  end

  assign pwm_o   = r_pwm;
  assign stall_o = r_stall;
  assign duty_o  = r_duty;

endmodule

// File: rtl/fan_ctrl_multi.sv
// Multi-fan PWM controller: shared prescaler and period counter feeding NumFans channels.
// PWM outputs lag the counter by one cycle; settings are sampled at each period wrap.
// No backpressure; en_i low synchronously zeroes timing, duty and watchdogs but keeps stall flags.
module fan_ctrl_multi
  import fan_ctrl_pkg::*;
#(
  parameter int NumFans      = 2,
  parameter int SettingWidth = 4,
  parameter int PwmWidth     = 8,
  parameter int PrescaleDiv  = 50,
  parameter int RampStep     = 16,
  parameter int TachTimeout  = 100000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [NumFans*SettingWidth-1:0] setting_i,
  input  logic [NumFans-1:0]              tach_i,
  input  logic [NumFans-1:0]              stall_clr_i,
  output logic [NumFans-1:0]              fan_pwm_o,
  output logic [NumFans-1:0]              stall_o,
  output logic [NumFans*PwmWidth-1:0]     duty_o
);

  localparam int                  PreWidth = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam logic [PreWidth-1:0] PreMax   = PreWidth'(PrescaleDiv - 1);
  localparam logic [PwmWidth-1:0] CntMax   = PwmWidth'(period_max(PwmWidth));

  logic [PreWidth-1:0] r_pre;
  logic [PwmWidth-1:0] r_cnt;
  logic                w_tick;
  logic                w_wrap;

  assign w_tick = en_i && (r_pre == PreMax);
  assign w_wrap = w_tick && (r_cnt == CntMax);

  // Prescaler: divides clk_i down to the PWM tick; held at zero while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pre <= '0;
    end else if (!en_i || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PreWidth'(1);
    end
  end

  // Period counter shared by all fans: 0..CntMax on ticks, restarting from 0 on enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!en_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= w_wrap ? '0 : (r_cnt + PwmWidth'(1));
    end
  end

  for (genvar g = 0; g < NumFans; g++) begin : g_chan
    fan_ctrl_chan #(
      .SettingWidth (SettingWidth),
      .PwmWidth     (PwmWidth),
      .RampStep     (RampStep),
      .TachTimeout  (TachTimeout)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .tick_i      (w_tick),
      .wrap_i      (w_wrap),
      .cnt_i       (r_cnt),
      .setting_i   (setting_i[g*SettingWidth +: SettingWidth]),
      .tach_i      (tach_i[g]),
      .stall_clr_i (stall_clr_i[g]),
      .pwm_o       (fan_pwm_o[g]),
      .stall_o     (stall_o[g]),
      .duty_o      (duty_o[g*PwmWidth +: PwmWidth])
    );
  end

endmodule
